decode_id: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline; the consumer of the IF/ID latch outputs (if_id_instr, if_id_npc) driven by the fetch stage.
- Contains the 32x32 register file (written from WB), the main control decoder and the 16-to-32 sign extender.
- Registers all results into the ID/EX latch, one cycle after the IF/ID values are presented.

---
 rtl/decode_id_if.sv | 29 ++
 rtl/decode_id.sv | 94 +++++++++
 tb/tb_decode_id.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/decode_id_if.sv
// rtl/decode_id_if.sv - IF/ID inputs, WB write port and ID/EX latch outputs of the decode stage
interface decode_id_if;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_rdata1;
  logic [31:0] id_ex_rdata2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;

  modport master (
    output if_id_instr, if_id_npc, wb_reg_write, wb_write_reg, wb_write_data,
    input  id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_rdata1, id_ex_rdata2,
           id_ex_sign_ext, id_ex_rt, id_ex_rd
  );

  modport slave (
    input  if_id_instr, if_id_npc, wb_reg_write, wb_write_reg, wb_write_data,
    output id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_rdata1, id_ex_rdata2,
           id_ex_sign_ext, id_ex_rt, id_ex_rd
  );
endinterface

// File: rtl/decode_id.sv
// rtl/decode_id.sv - MIPS ID stage: register file with WB write-through, control decode,
// sign extension and the ID/EX latch
module decode_id (
  input  logic       clk,
  input  logic       rst,
  decode_id_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [31:0] regs_q [32];

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        wb_we;
  logic [31:0] rdata1, rdata2, sign_ext;
  logic [1:0]  wb_d, wb_q;
  logic [2:0]  m_d, m_q;
  logic [3:0]  ex_d, ex_q;
  logic [31:0] npc_q, rdata1_q, rdata2_q, sign_ext_q;
  logic [4:0]  rt_q, rd_q;

  assign opcode   = bus.if_id_instr[31:26];
  assign rs       = bus.if_id_instr[25:21];
  assign rt       = bus.if_id_instr[20:16];
  assign rd       = bus.if_id_instr[15:11];
  assign imm      = bus.if_id_instr[15:0];
  assign sign_ext = {{16{imm[15]}}, imm};

  // r0 is never written, so it reads back as zero without a special case
  assign wb_we  = bus.wb_reg_write && (bus.wb_write_reg != 5'd0);
  assign rdata1 = (wb_we && bus.wb_write_reg == rs) ? bus.wb_write_data : regs_q[rs];
  assign rdata2 = (wb_we && bus.wb_write_reg == rt) ? bus.wb_write_data : regs_q[rt];

  // wb = {reg_write, mem_to_reg}, m = {branch, mem_read, mem_write},
  // ex = {reg_dst, alu_op[1:0], alu_src}; unknown opcodes become a bubble
  always_comb begin
    wb_d = 2'b00;
    m_d  = 3'b000;
    ex_d = 4'b0000;
    case (opcode)
      OP_RTYPE: begin wb_d = 2'b10; m_d = 3'b000; ex_d = 4'b1100; end
      OP_LW:    begin wb_d = 2'b11; m_d = 3'b010; ex_d = 4'b0001; end
      OP_SW:    begin wb_d = 2'b00; m_d = 3'b001; ex_d = 4'b0001; end
      OP_BEQ:   begin wb_d = 2'b00; m_d = 3'b100; ex_d = 4'b0010; end
      default:  begin wb_d = 2'b00; m_d = 3'b000; ex_d = 4'b0000; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wb_we) begin
      regs_q[bus.wb_write_reg] <= bus.wb_write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q       <= 2'b00;
      m_q        <= 3'b000;
      ex_q       <= 4'b0000;
      npc_q      <= 32'd0;
      rdata1_q   <= 32'd0;
      rdata2_q   <= 32'd0;
      sign_ext_q <= 32'd0;
      rt_q       <= 5'd0;
      rd_q       <= 5'd0;
    end else begin
      wb_q       <= wb_d;
      m_q        <= m_d;
      ex_q       <= ex_d;
      npc_q      <= bus.if_id_npc;
      rdata1_q   <= rdata1;
      rdata2_q   <= rdata2;
      sign_ext_q <= sign_ext;
      rt_q       <= rt;
      rd_q       <= rd;
    end
  end

  assign bus.id_ex_wb       = wb_q;
  assign bus.id_ex_m        = m_q;
  assign bus.id_ex_ex       = ex_q;
  assign bus.id_ex_npc      = npc_q;
  assign bus.id_ex_rdata1   = rdata1_q;
  assign bus.id_ex_rdata2   = rdata2_q;
  assign bus.id_ex_sign_ext = sign_ext_q;
  assign bus.id_ex_rt       = rt_q;
  assign bus.id_ex_rd       = rd_q;
endmodule

// File: tb/tb_decode_id.sv
// tb/tb_decode_id.sv - scoreboard bench for decode_id: directed vectors, queued
// expectations, monitor compares the ID/EX latch after each checked edge
module tb_decode_id;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_id_if bus ();

  decode_id dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] se;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  logic exp_v = 1'b0;
  int   total = 0;
  int   passed = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // drive one cycle of inputs at the falling edge; optionally queue the expected latch contents
  task automatic step(input logic [31:0] instr, input logic [31:0] npc,
                      input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                      input logic check, input exp_t e);
    @(negedge clk);
    bus.if_id_instr   = instr;
    bus.if_id_npc     = npc;
    bus.wb_reg_write  = we;
    bus.wb_write_reg  = wreg;
    bus.wb_write_data = wdata;
    exp_v = check;
    if (check) exp_q.push_back(e);
  endtask

  function automatic exp_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                              input logic [31:0] npc, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] se, input logic [4:0] rt, input logic [4:0] rd);
    exp_t e;
    e.wb = wb; e.m = m; e.ex = ex; e.npc = npc; e.rd1 = rd1; e.rd2 = rd2;
    e.se = se; e.rt = rt; e.rd = rd;
    return e;
  endfunction

  // monitor: after every edge whose inputs were marked for checking, pop and compare
  initial begin
    exp_t e;
    logic v;
    forever begin
      @(posedge clk);
      v = exp_v;
      #1;
      if (v && !rst) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
        end else begin
          e = exp_q.pop_front();
          chk("wb",       {30'd0, bus.id_ex_wb},  {30'd0, e.wb});
          chk("m",        {29'd0, bus.id_ex_m},   {29'd0, e.m});
          chk("ex",       {28'd0, bus.id_ex_ex},  {28'd0, e.ex});
          chk("npc",      bus.id_ex_npc,          e.npc);
          chk("rdata1",   bus.id_ex_rdata1,       e.rd1);
          chk("rdata2",   bus.id_ex_rdata2,       e.rd2);
          chk("sign_ext", bus.id_ex_sign_ext,     e.se);
          chk("rt",       {27'd0, bus.id_ex_rt},  {27'd0, e.rt});
          chk("rd",       {27'd0, bus.id_ex_rd},  {27'd0, e.rd});
        end
      end
    end
  end

  initial begin
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.if_id_instr = 32'd0; bus.if_id_npc = 32'd0;
    bus.wb_reg_write = 1'b0; bus.wb_write_reg = 5'd0; bus.wb_write_data = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_wb", {30'd0, bus.id_ex_wb}, 32'd0);
    chk("reset_rdata1", bus.id_ex_rdata1, 32'd0);
    rst = 1'b0;

    // WB writes r8 while a nop (R-type, all fields 0) decodes
    step(32'h0000_0000, 32'h4, 1, 5'd8, 32'h0000_1234, 1, mk(2'b10, 3'b000, 4'b1100, 32'h4, 0, 0, 0, 0, 0));
    // add r10,r8,r9
    step(32'h0109_5020, 32'h8, 0, 5'd0, 32'h0, 1, mk(2'b10, 3'b000, 4'b1100, 32'h8, 32'h1234, 0, 32'h5020, 5'd9, 5'd10));
    // same-cycle write r9 is bypassed into rdata2
    step(32'h0109_5020, 32'hC, 1, 5'd9, 32'hDEAD_BEEF, 1, mk(2'b10, 3'b000, 4'b1100, 32'hC, 32'h1234, 32'hDEAD_BEEF, 32'h5020, 5'd9, 5'd10));
    // array holds r9 afterwards
    step(32'h0109_5020, 32'h10, 0, 5'd0, 32'h0, 1, mk(2'b10, 3'b000, 4'b1100, 32'h10, 32'h1234, 32'hDEAD_BEEF, 32'h5020, 5'd9, 5'd10));
    // write to r0 with rs=0 in the same cycle must not bypass
    step(32'h0009_5020, 32'h14, 1, 5'd0, 32'hFFFF_FFFF, 1, mk(2'b10, 3'b000, 4'b1100, 32'h14, 0, 32'hDEAD_BEEF, 32'h5020, 5'd9, 5'd10));
    step(32'h0009_5020, 32'h18, 0, 5'd0, 32'h0, 1, mk(2'b10, 3'b000, 4'b1100, 32'h18, 0, 32'hDEAD_BEEF, 32'h5020, 5'd9, 5'd10));
    // lw r9,-4(r8)
    step(32'h8D09_FFFC, 32'h40, 0, 5'd0, 32'h0, 1, mk(2'b11, 3'b010, 4'b0001, 32'h40, 32'h1234, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd9, 5'd31));
    // sw r9,8(r8)
    step(32'hAD09_0008, 32'h44, 0, 5'd0, 32'h0, 1, mk(2'b00, 3'b001, 4'b0001, 32'h44, 32'h1234, 32'hDEAD_BEEF, 32'h8, 5'd9, 5'd0));
    // beq r8,r9,+3
    step(32'h1109_0003, 32'h48, 0, 5'd0, 32'h0, 1, mk(2'b00, 3'b100, 4'b0010, 32'h48, 32'h1234, 32'hDEAD_BEEF, 32'h3, 5'd9, 5'd0));
    // unknown opcode 0x3F: bubble, reads still latched; r5 written alongside
    step(32'hFD09_0010, 32'h4C, 1, 5'd5, 32'h0000_5555, 1, mk(2'b00, 3'b000, 4'b0000, 32'h4C, 32'h1234, 32'hDEAD_BEEF, 32'h10, 5'd9, 5'd0));

    // asynchronous reset mid-run with non-zero inputs
    step(32'h8D09_FFFC, 32'h60, 1, 5'd6, 32'h0000_6666, 0, none);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_wb",       {30'd0, bus.id_ex_wb}, 32'd0);
    chk("async_rst_m",        {29'd0, bus.id_ex_m},  32'd0);
    chk("async_rst_rdata1",   bus.id_ex_rdata1,      32'd0);
    chk("async_rst_rdata2",   bus.id_ex_rdata2,      32'd0);
    chk("async_rst_npc",      bus.id_ex_npc,         32'd0);
    chk("async_rst_sign_ext", bus.id_ex_sign_ext,    32'd0);
    @(negedge clk);
    bus.wb_reg_write = 1'b0;
    rst = 1'b0;
    // r5 was cleared by reset
    step(32'h00A0_0000, 32'h50, 0, 5'd0, 32'h0, 1, mk(2'b10, 3'b000, 4'b1100, 32'h50, 0, 0, 0, 0, 0));
    step(32'h0, 32'h0, 0, 5'd0, 32'h0, 0, none);

    repeat (20) begin
      if (exp_q.size() != 0) @(posedge clk);
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
